// File: rtl/debounce_pkg.sv
// debounce_pkg: shared scan-state type, event record and counter sizing helper
// for debounce_scan_ctrl.
package debounce_pkg;
  typedef enum logic {IDLE, SCAN} scan_state_t;
  localparam int EVT_CH_W = 8;
  typedef struct packed {
    logic [EVT_CH_W-1:0] ch;
    logic                level;
    logic                is_long;
  } evt_t;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/debounce_scan_ctrl_arbiter.sv
// event_rr_arbiter: combinational round-robin search that starts one past the
// last granted channel and wraps around.
module event_rr_arbiter
  import debounce_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CH_W-1:0]   ptr_i,
  output logic [CH_W-1:0]   gnt_o,
  output logic              gnt_valid_o
);
  logic [CH_W-1:0] c;
  // Walk from farthest to nearest so the nearest requester is written last.
  always_comb begin
    c           = '0;
    gnt_o       = '0;
    gnt_valid_o = 1'b0;
    for (int k = NUM_CH; k >= 1; k--) begin
      c = CH_W'((int'(ptr_i) + k) % NUM_CH);
      if (req_i[c]) begin
        gnt_o       = c;
        gnt_valid_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/debounce_scan_ctrl.sv
// debounce_scan_ctrl: NUM_CH button debouncer sharing one prescaler and counter datapath,
// with a round-robin valid/ready event stream. Define DEBOUNCE_SCAN_LONG_PRESS_EN for long-press events.
module debounce_scan_ctrl
  import debounce_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int TICK_CLKS    = 1200,
  parameter int STABLE_TICKS = 100,
`ifdef DEBOUNCE_SCAN_LONG_PRESS_EN
  parameter int LONG_TICKS   = 10000,
`endif
  localparam int CH_W = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] sig,
  output logic [NUM_CH-1:0] state,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CH_W-1:0]   evt_ch,
  output logic              evt_level,
  output logic              evt_long,
  output logic              evt_overrun
);
  localparam int CW = cnt_w(STABLE_TICKS);
  localparam int PW = cnt_w(TICK_CLKS);

  if (TICK_CLKS <= NUM_CH + 1) begin : g_bad_tick
    $error("TICK_CLKS must exceed NUM_CH+1 so a scan finishes before the next tick");
  end

  logic [NUM_CH-1:0] sync1_q, sync2_q, state_q, pend_q, pend_lvl_q, pend_d;
  logic [NUM_CH-1:0] set_vec, clr_lvl, req, lpend;
  logic [PW-1:0]     presc_q;
  logic [CW-1:0]     cnt_q [NUM_CH];
  scan_state_t       st_q, st_d;
  logic [CH_W-1:0]   idx_q, idx_d, ptr_q, gnt;
  logic              tick, last, scanning, cur_sync, cur_st, disagree, accept;
  logic              gnt_valid, load, take, is_lvl, ovr_d, ovr_q;
  logic              evt_valid_q, evt_valid_d;
  evt_t              evt_q, evt_d;
  logic              unused_evt;

  assign tick     = presc_q == PW'(TICK_CLKS - 1);
  assign last     = idx_q == CH_W'(NUM_CH - 1);
  assign scanning = st_q == SCAN;
  assign cur_sync = sync2_q[idx_q];
  assign cur_st   = state_q[idx_q];
  assign disagree = scanning && (cur_sync != cur_st);
  assign accept   = disagree && (cnt_q[idx_q] == CW'(STABLE_TICKS - 1));
  assign req      = pend_q | lpend;

  always_comb begin
    st_d  = (st_q == IDLE) ? (tick ? SCAN : IDLE) : (last ? IDLE : SCAN);
    idx_d = (scanning && !last) ? idx_q + CH_W'(1) : '0;
  end

  event_rr_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_arb (
    .req_i       (req),
    .ptr_i       (ptr_q),
    .gnt_o       (gnt),
    .gnt_valid_o (gnt_valid)
  );

  // A scan set and a grant clear of the same bit in one cycle: the set wins, no overrun.
  always_comb begin
    load        = !evt_valid_q || evt_ready;
    take        = load && gnt_valid;
    is_lvl      = pend_q[gnt];
    clr_lvl     = (take && is_lvl) ? (NUM_CH'(1) << gnt) : '0;
    set_vec     = accept ? (NUM_CH'(1) << idx_q) : '0;
    pend_d      = (pend_q & ~clr_lvl) | set_vec;
    ovr_d       = accept && pend_q[idx_q] && !clr_lvl[idx_q];
    evt_valid_d = load ? gnt_valid : evt_valid_q;
    evt_d       = take ? '{ch: EVT_CH_W'(gnt), level: is_lvl ? pend_lvl_q[gnt] : 1'b1, is_long: !is_lvl} : evt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      presc_q     <= '0;
      st_q        <= IDLE;
      idx_q       <= '0;
      state_q     <= '0;
      cnt_q       <= '{default: '0};
      pend_q      <= '0;
      pend_lvl_q  <= '0;
      ptr_q       <= CH_W'(NUM_CH - 1);
      evt_q       <= '0;
      evt_valid_q <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      sync1_q     <= sig;
      sync2_q     <= sync1_q;
      presc_q     <= tick ? '0 : presc_q + PW'(1);
      st_q        <= st_d;
      idx_q       <= idx_d;
      if (scanning) cnt_q[idx_q] <= (disagree && !accept) ? cnt_q[idx_q] + CW'(1) : '0;
      if (accept) begin
        state_q[idx_q]    <= cur_sync;
        pend_lvl_q[idx_q] <= cur_sync;
      end
      pend_q      <= pend_d;
      if (take) ptr_q <= gnt;
      evt_q       <= evt_d;
      evt_valid_q <= evt_valid_d;
      ovr_q       <= ovr_d;
    end
  end

`ifdef DEBOUNCE_SCAN_LONG_PRESS_EN
  localparam int LW = cnt_w(LONG_TICKS + 1);
  logic [LW-1:0]     hold_q [NUM_CH];
  logic [NUM_CH-1:0] lpend_q;
  logic              long_hit;
  assign long_hit = scanning && cur_st && (hold_q[idx_q] == LW'(LONG_TICKS - 1));
  // Hold counter saturates at LONG_TICKS so each press yields one long event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q  <= '{default: '0};
      lpend_q <= '0;
    end else begin
      if (scanning) hold_q[idx_q] <= !cur_st ? '0 : (hold_q[idx_q] == LW'(LONG_TICKS)) ? hold_q[idx_q] : hold_q[idx_q] + LW'(1);
      lpend_q <= (lpend_q & ~((take && !is_lvl) ? (NUM_CH'(1) << gnt) : '0)) | (long_hit ? (NUM_CH'(1) << idx_q) : '0);
    end
  end
  assign lpend    = lpend_q;
  assign evt_long = evt_q.is_long;
`else
  assign lpend    = '0;
  assign evt_long = 1'b0;
`endif

  assign unused_evt  = ^{evt_q.ch, evt_q.is_long};
  assign state       = state_q;
  assign evt_valid   = evt_valid_q;
  assign evt_ch      = evt_q.ch[CH_W-1:0];
  assign evt_level   = evt_q.level;
  assign evt_overrun = ovr_q;
endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// tb_debounce_scan_ctrl: directed scoreboard bench; stimulus queues expected events,
// a negedge monitor pops and compares on every handshake.
module tb_debounce_scan_ctrl;
  logic       clk = 1'b0, rst_n = 1'b0, evt_ready = 1'b1;
  logic [3:0] sig = 4'h0, state;
  logic       evt_valid, evt_level, evt_long, evt_overrun;
  logic [1:0] evt_ch;
  typedef struct {int ch; int lvl; int lng;} ev_t;
  ev_t exp_q[$];
  ev_t e;
  int  n_chk = 0, n_fail = 0, ovr_cnt = 0, ovr_base = 0;

  always #5 clk = ~clk;

  debounce_scan_ctrl #(
    .NUM_CH(4), .TICK_CLKS(8), .STABLE_TICKS(3)
`ifdef DEBOUNCE_SCAN_LONG_PRESS_EN
    , .LONG_TICKS(20)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .sig(sig), .state(state),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ch(evt_ch),
    .evt_level(evt_level), .evt_long(evt_long), .evt_overrun(evt_overrun)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int ch, input int lvl, input int lng);
    exp_q.push_back('{ch: ch, lvl: lvl, lng: lng});
  endtask

  task automatic wait_state(input logic [3:0] want, input string nm);
    for (int i = 0; i < 80 && state !== want; i++) step();
    chk(nm, 32'(state), 32'(want));
  endtask

  task automatic wait_drain(input int max, input string nm);
    for (int i = 0; i < max && exp_q.size() != 0; i++) step();
    chk(nm, exp_q.size(), 0);
    step(2);
  endtask

  always @(negedge clk) begin
    if (evt_overrun === 1'b1) ovr_cnt++;
    if (rst_n && evt_valid === 1'b1 && evt_ready) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got ch=%0d lvl=%0d long=%0d, expected no event", evt_ch, evt_level, evt_long);
      end else begin
        e = exp_q.pop_front();
        if (evt_ch !== 2'(e.ch) || evt_level !== 1'(e.lvl) || evt_long !== 1'(e.lng)) begin
          n_fail++;
          $display("FAIL event: got ch=%0d lvl=%0d long=%0d, expected ch=%0d lvl=%0d long=%0d",
                   evt_ch, evt_level, evt_long, e.ch, e.lvl, e.lng);
        end
      end
    end
  end

  initial begin
    sig = 4'hF;
    step(3);
    chk("rst_state", 32'(state), 0);
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_overrun", 32'(evt_overrun), 0);
    chk("rst_ch", 32'(evt_ch), 0);
`ifdef DEBOUNCE_SCAN_LONG_PRESS_EN
    sig = 4'h0;
    rst_n = 1'b1;
    step(10);
    push(2, 1, 0);
    push(2, 1, 1);
    sig = 4'b0100;
    wait_drain(400, "long_events");
    chk("long_state", 32'(state), 32'h4);
    push(2, 0, 0);
    sig = 4'h0;
    wait_drain(80, "long_release");
    step(40);
    chk("long_end_state", 32'(state), 0);
    chk("long_end_valid", 32'(evt_valid), 0);
`else
    // All four pressed through reset: accepted on the third scan, dispatched ch0..ch3.
    push(0, 1, 0); push(1, 1, 0); push(2, 1, 0); push(3, 1, 0);
    rst_n = 1'b1;
    step(20);
    chk("state_before_3_scans", 32'(state), 0);
    wait_state(4'hF, "all_pressed");
    wait_drain(40, "drain_t1");
    // ch1 bounces with a 6-clock period against 8-clock scans: never 3 disagreeing samples in a row.
    rst_n = 1'b0; sig = 4'h0; exp_q.delete();
    step(2);
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (i % 3 == 0) sig[1] = ~sig[1];
      step();
    end
    chk("bounce_no_accept", 32'(state), 0);
    sig[1] = 1'b1;
    push(1, 1, 0);
    wait_state(4'b0010, "ch1_stable");
    wait_drain(40, "drain_t2");
    // Output stalled on ch0; ch2 press then release overwrites its pending event.
    evt_ready = 1'b0;
    sig = 4'b0011;
    wait_state(4'b0011, "ch0_pressed");
    step(2);
    chk("hold_valid", 32'(evt_valid), 1);
    chk("hold_ch", 32'(evt_ch), 0);
    chk("hold_lvl", 32'(evt_level), 1);
    push(0, 1, 0); push(2, 0, 0);
    ovr_base = ovr_cnt;
    sig = 4'b0111;
    wait_state(4'b0111, "ch2_pressed");
    sig = 4'b0011;
    wait_state(4'b0011, "ch2_released");
    step(2);
    chk("overrun_pulses", 32'(ovr_cnt - ovr_base), 1);
    chk("stable_valid", 32'(evt_valid), 1);
    chk("stable_ch", 32'(evt_ch), 0);
    chk("stable_lvl", 32'(evt_level), 1);
    evt_ready = 1'b1;
    wait_drain(40, "drain_t3");
    // ch0/ch3 in one scan, then ch1/ch3 pending with pointer on ch3.
    rst_n = 1'b0; evt_ready = 1'b0; sig = 4'b1001; exp_q.delete();
    step(2);
    rst_n = 1'b1;
    wait_state(4'b1001, "ch0_ch3_same_scan");
    step(2);
    chk("t4_first_ch", 32'(evt_ch), 0);
    push(0, 1, 0); push(3, 1, 0); push(1, 1, 0); push(3, 0, 0);
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    step();
    chk("t4_second_valid", 32'(evt_valid), 1);
    chk("t4_second_ch", 32'(evt_ch), 3);
    sig = 4'b0011;
    wait_state(4'b0011, "ch1_ch3_pending");
    step(2);
    evt_ready = 1'b1;
    wait_drain(40, "drain_t4");
    // Reset in the middle of a scan with events pending and stalled.
    evt_ready = 1'b0;
    sig = 4'b1100;
    for (int i = 0; i < 80 && evt_valid !== 1'b1; i++) step();
    chk("t5_valid_before_rst", 32'(evt_valid), 1);
    step();
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(evt_valid), 0);
    chk("midrst_state", 32'(state), 0);
    exp_q.delete();
    sig = 4'h0;
    step(2);
    rst_n = 1'b1;
    evt_ready = 1'b1;
    step(60);
    chk("post_rst_valid", 32'(evt_valid), 0);
    chk("post_rst_state", 32'(state), 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
